fifo_burst_reader: RTL and testbench
====================================

// Module: fifo_burst_reader
// PURPOSE
//  Read-side drain engine for the asynchronous FIFO, running entirely in the rd_clk domain.
//  Pops a commanded number of words through the FIFO's rd_enb/empty/output_data interface.
//  The FIFO has 1-cycle read latency; this block presents the words as a valid/ready stream with m_last.
//  A 2-entry skid buffer absorbs that latency, so there is no data loss under back-pressure.
// PARAMETERS
//  DATA_WIDTH  8   word width; matches FIFO data width
//  LEN_W       8   width of burst length command; max burst 2**LEN_W-1 words
// PORTS
//  rd_clk        in   1           single clock (FIFO read clock)
//  rstn          in   1           asynchronous active-low reset
//  start         in   1           1-cycle burst request; sampled only in IDLE
//  cfg_len       in   LEN_W       words to read; sampled with start
//  busy          out  1           high from accepted start until burst completes
//  done          out  1           1-cycle pulse after final word handshake
//  fifo_empty    in   1           FIFO empty flag
//  fifo_rdata    in   DATA_WIDTH  FIFO output_data; valid the cycle after an accepted pop
//  fifo_rd_enb   out  1           FIFO pop request
//  m_data        out  DATA_WIDTH  stream data
//  m_valid       out  1           stream valid
//  m_ready       in   1           stream ready
//  m_last        out  1           marks final word of burst, qualified by m_valid
// BEHAVIOUR
//  Reset: busy, done, m_valid, m_last=0; m_data=0; fifo_rd_enb=0; FSM=IDLE; counters, buffer cleared.
//  Reset mid-burst: in-flight/buffered words discarded; next start begins a clean burst.
//  FSM IDLE:
//   - start & cfg_len!=0: latch len, go to BURST.
//   - start & cfg_len==0: stay IDLE, done=1 next cycle, no pops.
//  FSM BURST: issue pops until issued==len, then go to DRAIN.
//  FSM DRAIN: no pops. On handshake of word len, go to IDLE and pulse done the following cycle.
//  start while busy: ignored (no latch, no effect).
//  Pop rule (combinational):
//   - fifo_rd_enb = state==BURST & !fifo_empty & issued<len & credit>0
//   - credit = 2 - occ - inflight + (m_valid&m_ready)
//   - inflight = registered fifo_rd_enb from previous edge.
//   - fifo_rd_enb may depend combinationally on m_ready. m_valid/m_data never do (registered).
//  Capture: when inflight=1, fifo_rdata is written into the skid buffer at the next edge.
//  Latency: pop edge -> m_valid high 2 edges later. Full throughput (1 word/cycle) with m_ready=1.
//  Stream: m_data/m_valid/m_last held stable while m_valid & !m_ready (AXI-style, no retraction).
//  m_last: high on the word whose output count == len.
//  Counters: issued and out are LEN_W bits, never wrap (bounded by len); cleared on entering BURST.
//  Empty mid-burst: no pop while fifo_empty; burst stalls indefinitely, resumes when data arrives.
//  Simultaneous capture and pop in one cycle: buffer occupancy unchanged, order preserved (FIFO).
//  Overflow of skid buffer is impossible by credit rule; assert occ<=2 in simulation.
// STRUCTURE
//  Shared package fifo_pkg:
//   - DATA_WIDTH/ADDR_WIDTH/DEPTH constants (replacing the `defines)
//   - rd_state_t enum {IDLE,BURST,DRAIN}
//  Sub-module fifo_rd_skid: 2-entry registered buffer.
//   - Inputs: wr_en, wr_data.
//   - Outputs: m_valid/m_data.
//   - Exposes occ[1:0].
//  Top holds FSM, counters, credit logic.
// TESTING
//  1. FIFO holds 11,12,13,14; start, cfg_len=4, m_ready=1 -> 4 back-to-back pops; m_data 11..14 on consecutive cycles; m_last with 14; done 1 cycle later; busy low.
//  2. len=8, m_ready=0 for 6 cycles after start -> at most 2 pops issued; m_data=first word held stable; on release, all 8 words in order, none lost/duplicated.
//  3. FIFO holds 2 words, len=4 -> 2 words out, then fifo_rd_enb=0 while empty, busy=1; write 2 more -> remaining 2 out, m_last on 4th.
//  4. start with cfg_len=0 -> no fifo_rd_enb, done pulse next cycle, busy stays 0.
//  5. rstn low mid-burst (after 3 of 8 words) -> all outputs 0 immediately; after release, new start len=2 yields next 2 FIFO words with m_last correct.
//  6. second start pulse (cfg_len=5) during len=3 burst -> ignored; exactly 3 words, one done.

Source files
------------

// File: rtl/fifo_pkg.sv
// ============================================================================
// Module      : fifo_pkg
// Description : Shared constants and types for the asynchronous FIFO and its
//               read-side drain engine.
// Contents    : DATA_WIDTH / ADDR_WIDTH / DEPTH - FIFO geometry
//               rd_state_t                      - burst reader FSM encoding
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fifo_pkg;

    localparam int DATA_WIDTH = 8;
    localparam int ADDR_WIDTH = 4;
    localparam int DEPTH      = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DRAIN = 2'd2
    } rd_state_t;

endpackage : fifo_pkg

`default_nettype wire

// File: rtl/fifo_rd_skid.sv
// ============================================================================
// Module      : fifo_rd_skid
// Description : Two-entry registered buffer that absorbs the one-cycle read
//               latency of the FIFO. Entries leave in arrival order; the head
//               entry is presented as a registered valid/data stream.
// Ports       : rd_clk   - clock
//               rstn     - asynchronous active-low reset
//               wr_en    - capture wr_data this edge
//               wr_data  - word to capture
//               rd_en    - consumer accepted the head word this edge
//               m_valid  - head entry holds a word
//               m_data   - head word
//               occ      - number of entries held (0..2)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_rd_skid #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  rd_clk,
    input  logic                  rstn,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [1:0]            occ
);

    logic [DATA_WIDTH-1:0] head_q, head_d;
    logic [DATA_WIDTH-1:0] tail_q, tail_d;
    logic [1:0]            occ_q,  occ_d;
    logic                  pop;

    // A pop with nothing held is meaningless; masking it keeps occ sane.
    assign pop = rd_en & (occ_q != 2'd0);

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
        case ({wr_en, pop})
            2'b10: begin
                if (occ_q == 2'd0) begin
                    head_d = wr_data;
                end else begin
                    tail_d = wr_data;
                end
                occ_d = occ_q + 2'd1;
            end
            2'b01: begin
                head_d = tail_q;
                occ_d  = occ_q - 2'd1;
            end
            2'b11: begin
                // Occupancy unchanged; the older tail word advances to the
                // head so ordering is preserved.
                if (occ_q == 2'd2) begin
                    head_d = tail_q;
                    tail_d = wr_data;
                end else begin
                    head_d = wr_data;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge rd_clk or negedge rstn) begin
        if (!rstn) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= 2'd0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
`ifndef SYNTHESIS
            // The credit rule upstream must never let a third word arrive.
            assert (!(wr_en && !pop && occ_q == 2'd2));
`endif
        end
    end

    assign m_valid = (occ_q != 2'd0);
    assign m_data  = head_q;
    assign occ     = occ_q;

endmodule : fifo_rd_skid

`default_nettype wire

// File: rtl/fifo_burst_reader.sv
// ============================================================================
// Module      : fifo_burst_reader
// Description : Read-side drain engine for the asynchronous FIFO (rd_clk
//               domain). On a start command it pops cfg_len words through the
//               FIFO's rd_enb/empty/output_data interface and presents them as
//               a valid/ready stream with m_last. A two-entry skid buffer
//               absorbs the FIFO read latency so back-pressure loses nothing.
// Ports       : rd_clk, rstn           - clock, async active-low reset
//               start, cfg_len         - burst command (sampled in IDLE only)
//               busy, done             - status (done is a 1-cycle pulse)
//               fifo_empty, fifo_rdata - FIFO read side inputs
//               fifo_rd_enb            - FIFO pop request
//               m_data, m_valid, m_ready, m_last - output stream
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_burst_reader
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = fifo_pkg::DATA_WIDTH,
    parameter int LEN_W      = 8
) (
    input  logic                  rd_clk,
    input  logic                  rstn,
    input  logic                  start,
    input  logic [LEN_W-1:0]      cfg_len,
    output logic                  busy,
    output logic                  done,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_rdata,
    output logic                  fifo_rd_enb,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last
);

    rd_state_t        state_q, state_d;
    logic [LEN_W-1:0] len_q,    len_d;
    logic [LEN_W-1:0] issued_q, issued_d;
    logic [LEN_W-1:0] out_q,    out_d;
    logic             inflight_q;
    logic             done_q,   done_d;

    logic [1:0]       occ;
    logic             handshake;
    logic [2:0]       fill;
    logic [2:0]       limit;
    logic             has_credit;
    logic             last_word;

    assign handshake = m_valid & m_ready;

    // credit = 2 - occ - inflight + handshake, evaluated as a comparison so
    // no signed arithmetic is needed: a pop is allowed when the words already
    // held or on their way leave room for one more after this edge.
    assign fill       = {1'b0, occ} + {2'b00, inflight_q};
    assign limit      = 3'd2 + {2'b00, handshake};
    assign has_credit = (fill < limit);

    assign fifo_rd_enb = (state_q == BURST) & ~fifo_empty
                       & (issued_q < len_q) & has_credit;

    // The head word is number out_q+1 of the burst.
    assign last_word = ({1'b0, out_q} + {{LEN_W{1'b0}}, 1'b1}) == {1'b0, len_q};

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        issued_d = issued_q;
        out_d    = out_q;
        done_d   = 1'b0;

        if (handshake) begin
            out_d = out_q + {{(LEN_W-1){1'b0}}, 1'b1};
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (cfg_len != '0) begin
                        len_d    = cfg_len;
                        issued_d = '0;
                        out_d    = '0;
                        state_d  = BURST;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            BURST: begin
                if (fifo_rd_enb) begin
                    issued_d = issued_q + {{(LEN_W-1){1'b0}}, 1'b1};
                end
                if (issued_d == len_q) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (handshake && last_word) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge rd_clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            len_q      <= '0;
            issued_q   <= '0;
            out_q      <= '0;
            inflight_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            issued_q   <= issued_d;
            out_q      <= out_d;
            inflight_q <= fifo_rd_enb;
            done_q     <= done_d;
        end
    end

    // FIFO output_data is valid the cycle after a pop, i.e. while inflight_q.
    fifo_rd_skid #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .rd_clk  (rd_clk),
        .rstn    (rstn),
        .wr_en   (inflight_q),
        .wr_data (fifo_rdata),
        .rd_en   (handshake),
        .m_valid (m_valid),
        .m_data  (m_data),
        .occ     (occ)
    );

    assign m_last = m_valid & (state_q != IDLE) & last_word;
    assign busy   = (state_q != IDLE);
    assign done   = done_q;

endmodule : fifo_burst_reader

`default_nettype wire

// File: tb/tb_fifo_burst_reader.sv
// ============================================================================
// Module      : tb_fifo_burst_reader
// Description : Self-checking bench for fifo_burst_reader. A behavioural FIFO
//               with one-cycle read latency feeds the DUT; expected stream
//               words are queued when bursts are commanded and compared as
//               the DUT hands them over.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_burst_reader;

    localparam int DW = 8;
    localparam int LW = 8;

    logic          rd_clk;
    logic          rstn;
    logic          start;
    logic [LW-1:0] cfg_len;
    logic          busy;
    logic          done;
    logic          fifo_empty;
    logic [DW-1:0] fifo_rdata;
    logic          fifo_rd_enb;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready;
    logic          m_last;

    fifo_burst_reader #(
        .DATA_WIDTH (DW),
        .LEN_W      (LW)
    ) dut (
        .rd_clk      (rd_clk),
        .rstn        (rstn),
        .start       (start),
        .cfg_len     (cfg_len),
        .busy        (busy),
        .done        (done),
        .fifo_empty  (fifo_empty),
        .fifo_rdata  (fifo_rdata),
        .fifo_rd_enb (fifo_rd_enb),
        .m_data      (m_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_last      (m_last)
    );

    initial rd_clk = 1'b0;
    always #5 rd_clk = ~rd_clk;

    typedef struct packed {
        logic          last;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] fq[$];
    int            n_vec    = 0;
    int            n_err    = 0;
    int            pops     = 0;
    int            done_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Behavioural FIFO: pop at the edge, data valid the following cycle.
    initial begin
        fifo_empty = 1'b1;
        fifo_rdata = '0;
    end
    always @(posedge rd_clk) begin
        if (fifo_rd_enb && fq.size() > 0) begin
            fifo_rdata <= fq[0];
            fq.pop_front();
            pops++;
            fifo_empty <= (fq.size() == 0);
        end
    end

    task automatic fifo_write(input logic [DW-1:0] v);
        fq.push_back(v);
        fifo_empty = 1'b0;
    endtask

    task automatic push_burst(input logic [DW-1:0] base, input int len);
        for (int i = 0; i < len; i++) begin
            exp_q.push_back({(i == len - 1), base + DW'(i)});
        end
    endtask

    // Output monitor: scoreboard compare, stability under stall, pop sanity.
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data  = '0;
    logic          prev_last  = 1'b0;
    always @(negedge rd_clk) begin
        if (!rstn) begin
            prev_stall = 1'b0;
        end else begin
            if (fifo_rd_enb) begin
                chk("pop_while_empty", {31'd0, fifo_empty}, 32'd0);
            end
            if (prev_stall) begin
                chk("stall_valid", {31'd0, m_valid}, 32'd1);
                chk("stall_data", {24'd0, m_data}, {24'd0, prev_data});
                chk("stall_last", {31'd0, m_last}, {31'd0, prev_last});
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", {24'd0, m_data}, 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("word_data", {24'd0, m_data}, {24'd0, e.data});
                    chk("word_last", {31'd0, m_last}, {31'd0, e.last});
                end
            end
            if (done) done_cnt++;
            prev_stall = m_valid & ~m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge rd_clk);
        #1;
    endtask

    task automatic do_start(input int len);
        start   = 1'b1;
        cfg_len = LW'(len);
        tick(1);
        start   = 1'b0;
        cfg_len = '0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge rd_clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        chk(tag, {31'd0, seen}, 32'd1);
        tick(1);
    endtask

    initial begin
        int  p0;
        int  d0;
        int  k;
        bit  seen;
        logic [DW-1:0] a0;
        logic [DW-1:0] a1;

        rstn    = 1'b0;
        start   = 1'b0;
        cfg_len = '0;
        m_ready = 1'b0;
        #2;
        chk("rst_busy",   {31'd0, busy},        32'd0);
        chk("rst_done",   {31'd0, done},        32'd0);
        chk("rst_valid",  {31'd0, m_valid},     32'd0);
        chk("rst_last",   {31'd0, m_last},      32'd0);
        chk("rst_data",   {24'd0, m_data},      32'd0);
        chk("rst_rd_enb", {31'd0, fifo_rd_enb}, 32'd0);
        tick(2);
        rstn = 1'b1;
        tick(1);

        // 1: four words back-to-back with m_last on 14.
        for (int i = 11; i <= 14; i++) fifo_write(DW'(i));
        push_burst(8'd11, 4);
        m_ready = 1'b1;
        do_start(4);
        chk("t1_busy", {31'd0, busy}, 32'd1);
        seen = 1'b0;
        for (int j = 0; j < 10; j++) begin
            @(negedge rd_clk);
            if (m_valid) begin
                seen = 1'b1;
                break;
            end
        end
        chk("t1_first_valid", {31'd0, seen}, 32'd1);
        for (int j = 0; j < 3; j++) begin
            @(negedge rd_clk);
            chk("t1_back_to_back", {31'd0, m_valid}, 32'd1);
        end
        @(negedge rd_clk);
        chk("t1_done", {31'd0, done}, 32'd1);
        chk("t1_busy_low", {31'd0, busy}, 32'd0);
        tick(2);
        chk("t1_sb_empty", exp_q.size(), 32'd0);

        // 2: back-pressure for six cycles, then release.
        for (int i = 21; i <= 28; i++) fifo_write(DW'(i));
        push_burst(8'd21, 8);
        m_ready = 1'b0;
        p0 = pops;
        do_start(8);
        tick(6);
        chk("t2_pops_le2", {31'd0, (pops - p0) <= 2}, 32'd1);
        chk("t2_hold_valid", {31'd0, m_valid}, 32'd1);
        chk("t2_hold_data", {24'd0, m_data}, 32'd21);
        m_ready = 1'b1;
        wait_done("t2_done_timeout", 40);
        chk("t2_sb_empty", exp_q.size(), 32'd0);

        // 3: FIFO runs dry mid-burst, stalls, then resumes.
        fifo_write(8'd31);
        fifo_write(8'd32);
        push_burst(8'd31, 4);
        do_start(4);
        tick(8);
        chk("t3_busy_stall", {31'd0, busy}, 32'd1);
        chk("t3_no_pop", {31'd0, fifo_rd_enb}, 32'd0);
        chk("t3_two_out", exp_q.size(), 32'd2);
        fifo_write(8'd33);
        fifo_write(8'd34);
        wait_done("t3_done_timeout", 20);
        chk("t3_sb_empty", exp_q.size(), 32'd0);

        // 4: zero-length command.
        p0 = pops;
        do_start(0);
        chk("t4_done", {31'd0, done}, 32'd1);
        chk("t4_busy", {31'd0, busy}, 32'd0);
        chk("t4_rd_enb", {31'd0, fifo_rd_enb}, 32'd0);
        tick(1);
        chk("t4_done_pulse", {31'd0, done}, 32'd0);
        chk("t4_no_pops", pops - p0, 32'd0);

        // 5: reset in the middle of a burst, then a fresh short burst.
        for (int i = 41; i <= 50; i++) fifo_write(DW'(i));
        push_burst(8'd41, 8);
        d0 = done_cnt;
        do_start(8);
        k = 0;
        for (int j = 0; j < 20 && k < 3; j++) begin
            @(negedge rd_clk);
            if (m_valid) k++;
        end
        chk("t5_three_seen", k, 32'd3);
        @(posedge rd_clk);
        #2;
        rstn = 1'b0;
        #1;
        chk("t5_rst_valid", {31'd0, m_valid}, 32'd0);
        chk("t5_rst_last", {31'd0, m_last}, 32'd0);
        chk("t5_rst_data", {24'd0, m_data}, 32'd0);
        chk("t5_rst_busy", {31'd0, busy}, 32'd0);
        chk("t5_rst_done", {31'd0, done}, 32'd0);
        chk("t5_rst_rd_enb", {31'd0, fifo_rd_enb}, 32'd0);
        exp_q.delete();
        tick(2);
        rstn = 1'b1;
        tick(1);
        chk("t5_no_done", done_cnt - d0, 32'd0);
        a0 = fq[0];
        a1 = fq[1];
        exp_q.push_back({1'b0, a0});
        exp_q.push_back({1'b1, a1});
        do_start(2);
        wait_done("t5_done_timeout", 20);
        chk("t5_sb_empty", exp_q.size(), 32'd0);

        // 6: a second start during a burst is ignored.
        fq.delete();
        fifo_empty = 1'b1;
        for (int i = 61; i <= 63; i++) fifo_write(DW'(i));
        push_burst(8'd61, 3);
        d0 = done_cnt;
        do_start(3);
        tick(1);
        do_start(5);
        wait_done("t6_done_timeout", 20);
        tick(6);
        chk("t6_one_done", done_cnt - d0, 32'd1);
        chk("t6_idle", {31'd0, busy}, 32'd0);
        chk("t6_sb_empty", exp_q.size(), 32'd0);
        chk("t6_fifo_drained", fq.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_fifo_burst_reader

`default_nettype wire
